// File: rtl/alorium_lfsr_arb.sv
// Round-robin arbiter sharing one 8-bit XNOR LFSR among NUM_REQ requesters.
// Sequences seeding and stepping of the LFSR and hands one byte to each granted requester.
module alorium_lfsr_arb #(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned STEPS_PER_GRANT = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               seed_we,
    input  logic [7:0]         seed_val,
    input  logic [7:0]         lfsr_data,
    output logic               lfsr_new_seed,
    output logic               lfsr_enable,
    output logic [7:0]         lfsr_seed,
    output logic [NUM_REQ-1:0] gnt,
    output logic               rnd_valid,
    output logic [7:0]         rnd_data,
    output logic               busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEED = 2'd1;
    localparam logic [1:0] STEP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS_PER_GRANT - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    logic [1:0]         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic [IDX_W-1:0]   last, last_d;
    logic               seed_pend, seed_pend_d;
    logic [7:0]         lfsr_seed_d;
    logic [NUM_REQ-1:0] eligible;
    logic               found;
    logic [IDX_W-1:0]   win;

    // Round-robin pick starting just after the last winner; the current owner sits out in DONE.
    always_comb begin
        eligible = req;
        found    = 1'b0;
        win      = last;
        if (state == DONE) begin
            eligible = req & ~gnt;
        end
        for (int i = 1; i <= int'(NUM_REQ); i++) begin
            int idx;
            idx = (int'(last) + i) % int'(NUM_REQ);
            if (!found && eligible[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // Next-state: STEP counts out its cycles, every other state is a decision point.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        gnt_d       = gnt;
        last_d      = last;
        seed_pend_d = seed_pend | seed_we;
        lfsr_seed_d = seed_we ? seed_val : lfsr_seed;
        case (state)
            STEP: begin
                if (cnt == CNT_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (seed_pend || seed_we) begin
                    // The SEED cycle consumes whatever seed is latched at this edge.
                    state_d     = SEED;
                    seed_pend_d = 1'b0;
                    gnt_d       = '0;
                end else if (found) begin
                    state_d = STEP;
                    gnt_d   = NUM_REQ'(1) << win;
                    last_d  = win;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            gnt       <= '0;
            last      <= LAST_RST;
            seed_pend <= 1'b0;
            lfsr_seed <= 8'h00;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            gnt       <= gnt_d;
            last      <= last_d;
            seed_pend <= seed_pend_d;
            lfsr_seed <= lfsr_seed_d;
        end
    end

    assign lfsr_new_seed = (state == SEED);
    assign lfsr_enable   = (state == STEP);
    assign rnd_valid     = (state == DONE);
    assign rnd_data      = (state == DONE) ? lfsr_data : 8'h00;
    assign busy          = (state != IDLE);

endmodule
